// File: rtl/output_unit.sv
// output_unit
//   Transmit side of one router output link. Flits from switch traversal are
//   registered onto the link (LT stage) one cycle after acceptance. A credit
//   counter per VC mirrors free slots in the downstream input buffer, and a
//   per-VC held/free flag tracks which output VCs belong to in-flight packets.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   in_valid/in_flit/in_vc/in_tail   flit offered by the switch
//   in_ready            flit accepted this cycle when in_valid is high
//   credit_valid/credit_vc           one downstream slot freed on credit_vc
//   alloc_valid/alloc_vc             VC allocator claims alloc_vc
//   push/flit_out/vc_out             registered link outputs
//   credits             current credit count per VC (0..DEPTH)
//   vc_free             1 = VC not held by a packet
//   error               sticky protocol-violation flag
module output_unit #(
  parameter int DEPTH            = 4,
  parameter int DATA_WIDTH       = 32,
  parameter int VIRTUAL_CHANNELS = 2,
  parameter int VC_BITS          = $clog2(VIRTUAL_CHANNELS),
  parameter int DEPTH_BITS       = $clog2(DEPTH)
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         in_valid,
  input  logic [DATA_WIDTH-1:0]                        in_flit,
  input  logic [VC_BITS-1:0]                           in_vc,
  input  logic                                         in_tail,
  output logic                                         in_ready,
  input  logic                                         credit_valid,
  input  logic [VC_BITS-1:0]                           credit_vc,
  input  logic                                         alloc_valid,
  input  logic [VC_BITS-1:0]                           alloc_vc,
  output logic                                         push,
  output logic [DATA_WIDTH-1:0]                        flit_out,
  output logic [VC_BITS-1:0]                           vc_out,
  output logic [VIRTUAL_CHANNELS-1:0][DEPTH_BITS:0]    credits,
  output logic [VIRTUAL_CHANNELS-1:0]                  vc_free,
  output logic                                         error
);

  localparam logic [DEPTH_BITS:0] FULL = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] ONE  = (DEPTH_BITS+1)'(1);

  // Credit update for one VC. A return on a full counter saturates at DEPTH
  // (the overflow itself is flagged separately). Accept plus return nets out.
  function automatic logic [DEPTH_BITS:0] credit_next(
    input logic [DEPTH_BITS:0] cnt,
    input logic                inc,
    input logic                dec
  );
    credit_next = cnt;
    if (inc && !dec && cnt != FULL)
      credit_next = cnt + ONE;
    else if (dec && !inc)
      credit_next = cnt - ONE;
  endfunction

  logic                                      accept_p0;
  logic [VIRTUAL_CHANNELS-1:0]               dec_v, inc_v, rel_v, alc_v;
  logic [VIRTUAL_CHANNELS-1:0][DEPTH_BITS:0] credits_d;
  logic [VIRTUAL_CHANNELS-1:0]               vc_free_d;
  logic                                      error_d;

  // ---- p0: acceptance and bookkeeping from registered state ----
  assign in_ready  = (credits[in_vc] != '0);
  assign accept_p0 = in_valid && in_ready;

  always_comb begin
    dec_v     = '0;
    inc_v     = '0;
    rel_v     = '0;
    alc_v     = '0;
    credits_d = credits;
    vc_free_d = vc_free;
    error_d   = error;

    // Flit on an unallocated VC is still sent, but flagged.
    if (accept_p0 && vc_free[in_vc])
      error_d = 1'b1;

    for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
      dec_v[v] = accept_p0 && (in_vc == VC_BITS'(v));
      inc_v[v] = credit_valid && (credit_vc == VC_BITS'(v));
      rel_v[v] = dec_v[v] && in_tail;
      alc_v[v] = alloc_valid && (alloc_vc == VC_BITS'(v));

      if (inc_v[v] && !dec_v[v] && credits[v] == FULL)
        error_d = 1'b1;
      credits_d[v] = credit_next(credits[v], inc_v[v], dec_v[v]);

      // Re-allocating a held VC is legal only as a same-cycle tail hand-off.
      if (alc_v[v] && !vc_free[v] && !rel_v[v])
        error_d = 1'b1;
      if (alc_v[v])
        vc_free_d[v] = 1'b0;
      else if (rel_v[v])
        vc_free_d[v] = 1'b1;
    end
  end

  // ---- p1: link register and state ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push     <= 1'b0;
      flit_out <= '0;
      vc_out   <= '0;
      credits  <= {VIRTUAL_CHANNELS{FULL}};
      vc_free  <= '1;
      error    <= 1'b0;
    end else begin
      push     <= accept_p0;
      if (accept_p0) begin
        flit_out <= in_flit;
        vc_out   <= in_vc;
      end
      credits  <= credits_d;
      vc_free  <= vc_free_d;
      error    <= error_d;
    end
  end

endmodule

// File: tb/tb_output_unit.sv
module tb_output_unit;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int NVC   = 2;
  localparam int VB    = 1;
  localparam int DB    = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic [DW-1:0]            in_flit;
  logic [VB-1:0]            in_vc;
  logic                     in_tail;
  logic                     in_ready;
  logic                     credit_valid;
  logic [VB-1:0]            credit_vc;
  logic                     alloc_valid;
  logic [VB-1:0]            alloc_vc;
  logic                     push;
  logic [DW-1:0]            flit_out;
  logic [VB-1:0]            vc_out;
  logic [NVC-1:0][DB:0]     credits;
  logic [NVC-1:0]           vc_free;
  logic                     error;

  always #5 clk = ~clk;

  output_unit #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .VIRTUAL_CHANNELS(NVC)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_flit(in_flit), .in_vc(in_vc), .in_tail(in_tail),
    .in_ready(in_ready),
    .credit_valid(credit_valid), .credit_vc(credit_vc),
    .alloc_valid(alloc_valid), .alloc_vc(alloc_vc),
    .push(push), .flit_out(flit_out), .vc_out(vc_out),
    .credits(credits), .vc_free(vc_free), .error(error)
  );

  typedef struct {
    logic [DW-1:0] f;
    logic [VB-1:0] v;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  // Reference model: credits as plain integers, held flags, sticky error.
  int   mcred[NVC];
  bit   mfree[NVC];
  bit   merr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NVC; i++) begin
      mcred[i] = DEPTH;
      mfree[i] = 1'b1;
    end
    merr = 1'b0;
    sb.delete();
  endtask

  task automatic drive_idle();
    in_valid = 0; in_flit = '0; in_vc = '0; in_tail = 0;
    credit_valid = 0; credit_vc = '0; alloc_valid = 0; alloc_vc = '0;
  endtask

  // Called at a falling edge; asserts reset asynchronously and checks at once.
  task automatic do_reset();
    drive_idle();
    reset = 1'b0;
    #1;
    chk("rst_push", push, 0);
    chk("rst_flit_out", flit_out, 0);
    chk("rst_vc_out", vc_out, 0);
    for (int i = 0; i < NVC; i++) chk($sformatf("rst_credits%0d", i), credits[i], DEPTH);
    chk("rst_vc_free", vc_free, 2'b11);
    chk("rst_error", error, 0);
    chk("rst_in_ready", in_ready, 1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One cycle: drive at the falling edge, predict, check state after the edge.
  task automatic step(input bit v, input logic [DW-1:0] f, input logic [VB-1:0] vc,
                      input bit tl, input bit cv, input logic [VB-1:0] cvc,
                      input bit av, input logic [VB-1:0] avc);
    bit rdy, acc;
    int nc[NVC];
    bit nf[NVC];
    logic [NVC-1:0] fv;
    in_valid = v; in_flit = f; in_vc = vc; in_tail = tl;
    credit_valid = cv; credit_vc = cvc; alloc_valid = av; alloc_vc = avc;
    #1;
    rdy = (mcred[vc] != 0);
    chk("in_ready", in_ready, rdy);
    acc = v && rdy;
    nc = mcred;
    nf = mfree;
    if (acc) begin
      exp_t e;
      e.f = f; e.v = vc;
      sb.push_back(e);
      nc[vc] = nc[vc] - 1;
      if (mfree[vc]) merr = 1'b1;
    end
    if (cv) begin
      if (nc[cvc] >= DEPTH) merr = 1'b1;
      else nc[cvc] = nc[cvc] + 1;
    end
    if (av && !mfree[avc] && !(acc && tl && vc == avc)) merr = 1'b1;
    if (acc && tl) nf[vc] = 1'b1;
    if (av) nf[avc] = 1'b0;
    @(posedge clk);
    mcred = nc;
    mfree = nf;
    #2;
    chk("push", push, acc);
    for (int i = 0; i < NVC; i++) begin
      chk($sformatf("credits%0d", i), credits[i], mcred[i]);
      fv[i] = mfree[i];
    end
    chk("vc_free", vc_free, fv);
    chk("error", error, merr);
    @(negedge clk);
  endtask

  task automatic idle();                     step(0, '0, 0, 0, 0, 0, 0, 0); endtask
  task automatic send(input logic [VB-1:0] vc, input bit tl); step(1, $urandom(), vc, tl, 0, 0, 0, 0); endtask
  task automatic ret(input logic [VB-1:0] vc);  step(0, '0, 0, 0, 1, vc, 0, 0); endtask
  task automatic alloc(input logic [VB-1:0] vc); step(0, '0, 0, 0, 0, 0, 1, vc); endtask

  // Monitor: every link flit must match the oldest accepted flit.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (push === 1'b1) begin
        if (sb.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_push: got flit %0h with empty scoreboard at %0t", flit_out, $time);
        end else begin
          e = sb.pop_front();
          chk("flit_out", flit_out, e.f);
          chk("vc_out", vc_out, e.v);
        end
      end
    end
  end

  initial begin
    drive_idle();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset in the middle of traffic, with a flit on the link.
    alloc(0);
    send(0, 0);
    chk("pre_reset_push", push, 1);
    do_reset();

    // Drain VC0: four accepts then backpressure.
    alloc(0);
    for (int i = 0; i < 5; i++) send(0, 0);
    chk("vc0_drained", credits[0], 0);
    in_vc = 0; #1;
    chk("vc0_not_ready", in_ready, 0);
    chk("drain_no_error", error, 0);

    // Simultaneous accept and return on VC1 with two credits.
    alloc(1);
    send(1, 0);
    send(1, 0);
    step(1, $urandom(), 1, 0, 1, 1, 0, 0);
    chk("vc1_net_zero", credits[1], 2);
    chk("vc1_net_push", push, 1);
    send(1, 1);
    ret(1);
    ret(1);

    // Alloc, head, tail on VC1.
    alloc(1);
    chk("vc1_held", vc_free[1], 0);
    send(1, 0);
    send(1, 1);
    chk("vc1_released", vc_free[1], 1);

    // Tail accept with same-cycle re-allocation is a legal hand-off.
    ret(1);
    alloc(1);
    send(1, 0);
    step(1, $urandom(), 1, 1, 0, 0, 1, 1);
    chk("handoff_held", vc_free[1], 0);
    chk("handoff_no_error", error, 0);

    // Credit overflow on VC0.
    for (int i = 0; i < 4; i++) ret(0);
    ret(0);
    chk("ovf_credits", credits[0], 4);
    chk("ovf_error", error, 1);
    idle();
    chk("ovf_sticky", error, 1);

    // Alloc on a held VC without a tail.
    do_reset();
    alloc(0);
    alloc(0);
    chk("realloc_error", error, 1);

    // Mostly-legal random traffic.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      logic [VB-1:0] vc, cvc;
      bit v, tl, cv, av;
      vc  = VB'($urandom_range(0, NVC-1));
      cvc = VB'($urandom_range(0, NVC-1));
      av  = mfree[vc] && ($urandom_range(0, 3) == 0);
      v   = !mfree[vc] && ($urandom_range(0, 3) != 0);
      tl  = ($urandom_range(0, 3) == 0);
      cv  = (mcred[cvc] < DEPTH) && ($urandom_range(0, 1) == 1);
      step(v, $urandom(), vc, tl, cv, cvc, av, vc);
    end
    chk("random_legal_no_error", error, 0);

    // Unconstrained random traffic, including protocol violations.
    do_reset();
    for (int n = 0; n < 150; n++) begin
      step($urandom_range(0, 1), $urandom(), VB'($urandom_range(0, NVC-1)), $urandom_range(0, 1),
           $urandom_range(0, 1), VB'($urandom_range(0, NVC-1)),
           ($urandom_range(0, 3) == 0), VB'($urandom_range(0, NVC-1)));
    end

    idle();
    idle();
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
